// File: rtl/axis_downsizer.sv
// AXI-Stream width downsizer: splits each wide input beat into RATIO narrow sub-beats,
// skipping sub-beats whose keep slice is empty and tagging the packet's final sub-beat.
module axis_downsizer #(
   parameter int WORD_W  = 8,
   parameter int BUS_I_W = 32,
   parameter int BUS_O_W = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [BUS_I_W-1:0] s_data,
   input  logic [BUS_I_W/WORD_W-1:0] s_keep,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [BUS_O_W-1:0] m_data,
   output logic [BUS_O_W/WORD_W-1:0] m_keep,
   output logic               m_last
);

   localparam int WI    = BUS_I_W / WORD_W;
   localparam int WO    = BUS_O_W / WORD_W;
   localparam int RATIO = BUS_I_W / BUS_O_W;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   typedef enum logic {EMPTY, BUSY} state_t;

   state_t             state;
   logic [BUS_I_W-1:0] buf_data;
   logic [WI-1:0]      buf_keep;
   logic               buf_last;
   logic [RATIO-1:0]   pend;      // sub-beats of the buffered beat still to be emitted
   logic [IDX_W-1:0]   idx;

   logic [RATIO-1:0]   pend_rest;
   logic [RATIO-1:0]   new_mask;
   logic               final_sub;
   logic               s_fire;
   logic               m_fire;

   // A keep-less beat carrying last still emits sub-beat 0 so the packet boundary survives.
   function automatic logic [RATIO-1:0] emit_mask(input logic [WI-1:0] keep, input logic last);
      logic [RATIO-1:0] m;
      m = '0;
      for (int k = 0; k < RATIO; k++) m[k] = |keep[k*WO +: WO];
      if (m == '0 && last) m[0] = 1'b1;
      return m;
   endfunction

   function automatic logic [IDX_W-1:0] lowest(input logic [RATIO-1:0] m);
      logic [IDX_W-1:0] lo;
      lo = '0;
      for (int k = RATIO - 1; k >= 0; k--) if (m[k]) lo = IDX_W'(k);
      return lo;
   endfunction

   always_comb begin
      pend_rest = pend & ~(RATIO'(1) << idx);
      final_sub = (pend_rest == '0);
      new_mask  = emit_mask(s_keep, s_last);
      m_valid   = rstn && (state == BUSY);
      s_ready   = rstn && ((state == EMPTY) || (m_ready && final_sub));
      s_fire    = s_valid && s_ready;
      m_fire    = m_valid && m_ready;
      m_data    = m_valid ? buf_data[idx*BUS_O_W +: BUS_O_W] : '0;
      m_keep    = m_valid ? buf_keep[idx*WO +: WO] : '0;
      m_last    = m_valid && buf_last && final_sub;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // NOTE: buf_data is pure datapath qualified by state, so it is deliberately left unreset.
         state    <= EMPTY;
         idx      <= '0;
         buf_keep <= '0;
         buf_last <= 1'b0;
         pend     <= '0;
      end else if (s_fire) begin
         buf_data <= s_data;
         buf_keep <= s_keep;
         buf_last <= s_last;
         pend     <= new_mask;
         idx      <= lowest(new_mask);
         state    <= (new_mask != '0) ? BUSY : EMPTY;
      end else if (m_fire) begin
         pend <= pend_rest;
         idx  <= lowest(pend_rest);
         if (final_sub) state <= EMPTY;
      end
   end

endmodule

// File: doc/axis_downsizer.md
AXIS_DOWNSIZER -- requirements
Module: axis_downsizer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning the word granularity in bits; keep carries one bit per word.
REQ-002 The block SHALL have parameter BUS_I_W, default 32, meaning the input data width in bits; it is a multiple of BUS_O_W.
REQ-003 The block SHALL have parameter BUS_O_W, default 8, meaning the output data width in bits; it is a multiple of WORD_W.
REQ-004 The block SHALL derive localparams WI=BUS_I_W/WORD_W, WO=BUS_O_W/WORD_W and RATIO=BUS_I_W/BUS_O_W.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-008 The block SHALL have port s_ready, output, 1 bit: input beat accepted.
REQ-009 The block SHALL have port s_data, input, BUS_I_W bits: input words; word 0 is in the LSBs.
REQ-010 The block SHALL have port s_keep, input, WI bits: per-word byte-enable style qualifier.
REQ-011 The block SHALL have port s_last, input, 1 bit: final beat of the packet.
REQ-012 The block SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-013 The block SHALL have port m_ready, input, 1 bit: output beat accepted.
REQ-014 The block SHALL have port m_data, output, BUS_O_W bits: output words.
REQ-015 The block SHALL have port m_keep, output, WO bits: per-word qualifier of the output beat.
REQ-016 The block SHALL have port m_last, output, 1 bit: final output beat of the packet.

Function
REQ-017 A transfer SHALL occur on a rising edge where valid and ready are both high; no other edge transfers.
REQ-018 The block SHALL hold an accepted input beat in a buffer (data, keep, last) plus a sub-beat index idx, 0..RATIO-1.
REQ-019 The block SHALL use two states: EMPTY (buffer free) and BUSY (buffer holds a beat).
REQ-020 Sub-beat k SHALL be words k*WO..k*WO+WO-1 of the buffer, output with the matching keep bits.
REQ-021 Sub-beat k SHALL be emitted only if its keep slice is non-zero; sub-beats with an all-zero slice SHALL be skipped in zero cycles.
REQ-022 The final sub-beat of a buffered beat SHALL be the highest-indexed sub-beat with non-zero keep.
REQ-023 m_last SHALL be 1 only on the final sub-beat of a beat that had s_last=1.
REQ-024 An input beat with s_keep all zero and s_last=1 SHALL emit exactly one sub-beat: sub-beat 0 with m_keep=0 and m_last=1.
REQ-025 An input beat with s_keep all zero and s_last=0 SHALL be consumed without emitting anything.
REQ-026 s_ready SHALL be 1 in EMPTY, and 1 in BUSY only in the cycle the final sub-beat transfers on the output.
REQ-027 The block SHALL therefore sustain back-to-back input beats with no bubble.
REQ-028 s_ready SHALL NOT depend combinationally on s_valid.
REQ-029 Latency from an input transfer to m_valid=1 SHALL be one cycle.
REQ-030 m_valid SHALL be 1 exactly when the state is BUSY and an emittable sub-beat remains.
REQ-031 While m_valid=1 and m_ready=0, m_data, m_keep and m_last SHALL remain stable.
REQ-032 On each output transfer, idx SHALL advance to the next emittable sub-beat.
REQ-033 After the final output transfer, the state SHALL go to EMPTY, or stay BUSY with idx reset if a new input beat transfers in the same cycle.
REQ-034 The block SHALL provide full throughput of one output beat per cycle whenever m_ready=1 and input is available.
REQ-035 With RATIO=1 the block SHALL act as a one-deep register slice with the same keep/last rules.

Reset
REQ-036 While rstn=0 at a rising edge, the block SHALL set state EMPTY, idx=0, buffer last=0 and buffer keep=0.
REQ-037 While rstn=0, the block SHALL drive m_valid=0 and s_ready=0; m_data, m_keep and m_last SHALL be 0.
REQ-038 A reset in mid-packet SHALL discard the buffered beat; the first cycle after rstn=1 SHALL have s_ready=1 and m_valid=0.

Verification (WORD_W=8, BUS_I_W=32, BUS_O_W=8)
REQ-039 Bench SHALL cover: input 0x44332211, keep=1111, last=1, m_ready=1 -> outputs 11,22,33,44 on four consecutive cycles; m_last only on 44.
REQ-040 Bench SHALL cover: input keep=0011, last=1 -> two outputs (words 0 and 1); the second has m_last=1; s_ready high in the second output's cycle.
REQ-041 Bench SHALL cover: input keep=0101 -> outputs word 0 then word 2; sub-beats 1 and 3 are never emitted.
REQ-042 Bench SHALL cover: input keep=0000 with last=1 -> one beat, m_keep=0, m_last=1; input keep=0000 with last=0 -> no output.
REQ-043 Bench SHALL cover: random m_ready (30%) and random s_valid (30%) over 50 ten-beat packets -> output word stream and last markers equal the keep-filtered reference; m_* stable while stalled.
REQ-044 Bench SHALL cover: rstn=0 pulsed after the second output of a 4-word beat -> m_valid=0 the next cycle; the next packet is emitted intact with no residual words.
